// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_arbiter
//  Description : Two-port (CPU "C", DMA/debug "D") arbiter in front of a
//                single-port, byte-addressed, big-endian 32-bit data memory.
//                One access per two cycles, registered read response,
//                misaligned/out-of-range accesses rejected with an error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_BYTES    = 128,
    parameter int CPU_PRIORITY = 1,
    parameter int MAX_WAIT     = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    // port C (CPU load/store stage)
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_err,
    // port D (DMA/debug loader)
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    // DataMemory side
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [DATA_W-1:0] ReadData
);

    localparam int              c_CW        = $clog2(MAX_WAIT + 1);
    localparam logic [c_CW-1:0] c_WAIT_MAX  = c_CW'(MAX_WAIT);
    // Highest legal word address, widened by one bit so a large address
    // can never wrap into the legal range.
    localparam logic [ADDR_W:0] c_LAST_WORD = (ADDR_W + 1)'(MEM_BYTES - 4);
    localparam logic            c_OWN_C     = 1'b0;
    localparam logic            c_OWN_D     = 1'b1;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_we;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    // Owner of the current/most recent access; doubles as the round-robin
    // history, so it resets to D to favour C first.
    logic              r_owner;
    logic [c_CW-1:0]   r_c_wait;
    logic [c_CW-1:0]   r_d_wait;

    logic              r_c_rvalid;
    logic              r_d_rvalid;
    logic              r_c_err;
    logic              r_d_err;
    logic [DATA_W-1:0] r_c_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic              w_c_win;
    logic              w_d_win;
    logic              w_any_win;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_err;

    // Winner selection; only evaluated in IDLE and never while reset is held.
    always_comb begin
        w_c_win = 1'b0;
        w_d_win = 1'b0;
        if (r_state == S_IDLE && reset_n) begin
            if (c_req && d_req) begin
                if (r_c_wait == c_WAIT_MAX) begin
                    w_c_win = 1'b1;
                end else if (r_d_wait == c_WAIT_MAX) begin
                    w_d_win = 1'b1;
                end else if (CPU_PRIORITY != 0) begin
                    w_c_win = 1'b1;
                end else if (r_owner == c_OWN_D) begin
                    w_c_win = 1'b1;
                end else begin
                    w_d_win = 1'b1;
                end
            end else if (c_req) begin
                w_c_win = 1'b1;
            end else if (d_req) begin
                w_d_win = 1'b1;
            end
        end
    end

    assign w_any_win   = w_c_win | w_d_win;
    assign w_sel_we    = w_d_win ? d_we    : c_we;
    assign w_sel_addr  = w_d_win ? d_addr  : c_addr;
    assign w_sel_wdata = w_d_win ? d_wdata : c_wdata;
    assign w_sel_err   = (w_sel_addr[1:0] != 2'b00) |
                         ({1'b0, w_sel_addr} > c_LAST_WORD);

    // Next-state: a grant moves to ACCESS, ACCESS always lasts one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_any_win) w_state_nxt = S_ACCESS;
            S_ACCESS: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Latch the winning command, its range/alignment verdict and its owner.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_owner <= c_OWN_D;
        end else if (w_any_win) begin
            r_we    <= w_sel_we;
            r_err   <= w_sel_err;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_owner <= w_d_win ? c_OWN_D : c_OWN_C;
        end
    end

    // Starvation counters: a losing requester counts up (saturating), a
    // winner or idle port clears; frozen while the memory is busy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_c_wait <= '0;
            r_d_wait <= '0;
        end else if (r_state == S_IDLE) begin
            if (c_req && w_d_win)
                r_c_wait <= (r_c_wait == c_WAIT_MAX) ? r_c_wait : r_c_wait + c_CW'(1);
            else
                r_c_wait <= '0;
            if (d_req && w_c_win)
                r_d_wait <= (r_d_wait == c_WAIT_MAX) ? r_d_wait : r_d_wait + c_CW'(1);
            else
                r_d_wait <= '0;
        end
    end

    // Response to the owner at the edge that ends ACCESS; rdata of the
    // other port is left untouched, and writes keep the last read data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_c_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_c_err    <= 1'b0;
            r_d_err    <= 1'b0;
            r_c_rdata  <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_c_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_c_err    <= 1'b0;
            r_d_err    <= 1'b0;
            if (r_state == S_ACCESS) begin
                if (r_owner == c_OWN_C) begin
                    r_c_rvalid <= 1'b1;
                    r_c_err    <= r_err;
                    if (r_err)      r_c_rdata <= '0;
                    else if (!r_we) r_c_rdata <= ReadData;
                end else begin
                    r_d_rvalid <= 1'b1;
                    r_d_err    <= r_err;
                    if (r_err)      r_d_rdata <= '0;
                    else if (!r_we) r_d_rdata <= ReadData;
                end
            end
        end
    end

    assign c_gnt     = w_c_win;
    assign d_gnt     = w_d_win;
    assign c_rvalid  = r_c_rvalid;
    assign d_rvalid  = r_d_rvalid;
    assign c_err     = r_c_err;
    assign d_err     = r_d_err;
    assign c_rdata   = r_c_rdata;
    assign d_rdata   = r_d_rdata;

    // Strobes come straight from state so an async reset kills them at once.
    assign Address   = r_addr;
    assign WriteData = r_wdata;
    assign MemWrite  = (r_state == S_ACCESS) &  r_we & ~r_err;
    assign MemRead   = (r_state == S_ACCESS) & ~r_we & ~r_err;

endmodule
`default_nettype wire
